muldiv_sequencer: RTL

- Multi-cycle execution controller for the RV32M ops (SELECT 6'b001xxx) in the EX stage; the single-cycle ALU keeps every other op.
- Latches operands and sequences either a fixed-latency multiply or a 32-iteration restoring divide.
- Drives a pipeline STALL and a one-cycle RESULT_VALID.
- Owns the RISC-V divide-by-zero and signed-overflow rules.

---
 rtl/muldiv_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M execution sequencer: latches an M-op in EX, runs a fixed-latency multiply
// or a 32-step restoring divide, stalls the pipe and pulses RESULT_VALID on completion.
module muldiv_sequencer #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [5:0]  SELECT,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic        FLUSH,
    output logic        STALL,
    output logic        BUSY,
    output logic [31:0] RESULT,
    output logic        RESULT_VALID
);

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DONE} state_t;

    state_t      state, state_n;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic [5:0]  cnt;
    logic [31:0] rem, quo, dvs;
    logic        qsign, rsign;

    logic        is_mop, accept, div_zero, div_ovf, fast;
    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [31:0] mul_a, mul_b, mul_res;
    logic [2:0]  mul_f;
    logic        sa, sb;
    logic [63:0] ma, mb, prod;
    logic [32:0] shifted, trial;
    logic        take;
    logic [31:0] rem_step, quo_step, quo_fix, rem_fix, div_res, fast_res, result_n;

    assign is_mop   = (SELECT[5:3] == 3'b001);
    assign accept   = (state == IDLE) && START && is_mop && !FLUSH;
    assign div_zero = (DATA2 == 32'h0);
    assign div_ovf  = !SELECT[0] && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
    assign fast     = SELECT[2] && (div_zero || div_ovf);

    assign a_neg = !SELECT[0] && DATA1[31];
    assign b_neg = !SELECT[0] && DATA2[31];
    assign abs_a = a_neg ? -DATA1 : DATA1;
    assign abs_b = b_neg ? -DATA2 : DATA2;

    // Multiplier reads the live inputs in IDLE so MUL_CYCLES=1 can finish at accept.
    assign mul_a   = (state == IDLE) ? DATA1 : opa;
    assign mul_b   = (state == IDLE) ? DATA2 : opb;
    assign mul_f   = (state == IDLE) ? SELECT[2:0] : op;
    assign sa      = (mul_f == 3'b001) || (mul_f == 3'b010);
    assign sb      = (mul_f == 3'b001);
    assign ma      = {{32{sa & mul_a[31]}}, mul_a};
    assign mb      = {{32{sb & mul_b[31]}}, mul_b};
    assign prod    = ma * mb;
    assign mul_res = (mul_f == 3'b000) ? prod[31:0] : prod[63:32];

    // Partial remainder stays below 2*divisor, so the 33-bit trial difference cannot wrap.
    assign shifted  = {rem, quo[31]};
    assign trial    = shifted - {1'b0, dvs};
    assign take     = !trial[32];
    assign rem_step = take ? trial[31:0] : shifted[31:0];
    assign quo_step = {quo[30:0], take};

    assign quo_fix  = qsign ? -quo : quo;
    assign rem_fix  = rsign ? -rem : rem;
    assign div_res  = op[1] ? rem_fix : quo_fix;
    assign fast_res = div_zero ? (SELECT[1] ? DATA1 : 32'hFFFF_FFFF)
                               : (SELECT[1] ? 32'h0 : 32'h8000_0000);

    always_comb begin
        result_n = RESULT;
        case (state)
            IDLE:     result_n = SELECT[2] ? fast_res : mul_res;
            MUL_WAIT: result_n = mul_res;
            DIV_RUN:  result_n = div_res;
            default:  result_n = RESULT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (SELECT[2]) state_n = fast ? DONE : DIV_RUN;
                    else           state_n = (MUL_CYCLES == 1) ? DONE : MUL_WAIT;
                end
            end
            MUL_WAIT: begin
                if (FLUSH)          state_n = IDLE;
                else if (cnt == 0)  state_n = DONE;
            end
            DIV_RUN: begin
                if (FLUSH)              state_n = IDLE;
                else if (cnt == 6'd32)  state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        STALL = 1'b0;
        case (state)
            IDLE:             STALL = START && is_mop && !FLUSH;
            MUL_WAIT, DIV_RUN: STALL = 1'b1;
            default:          STALL = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            BUSY         <= 1'b0;
            RESULT_VALID <= 1'b0;
            RESULT       <= 32'h0;
            op           <= 3'h0;
            opa          <= 32'h0;
            opb          <= 32'h0;
            cnt          <= 6'h0;
            rem          <= 32'h0;
            quo          <= 32'h0;
            dvs          <= 32'h0;
            qsign        <= 1'b0;
            rsign        <= 1'b0;
        end else begin
            BUSY         <= (state_n == MUL_WAIT) || (state_n == DIV_RUN);
            RESULT_VALID <= (state_n == DONE);
            if (state_n == DONE) RESULT <= result_n;
            if (accept) begin
                op    <= SELECT[2:0];
                opa   <= DATA1;
                opb   <= DATA2;
                rem   <= 32'h0;
                quo   <= abs_a;
                dvs   <= abs_b;
                qsign <= a_neg ^ b_neg;
                rsign <= a_neg;
                cnt   <= SELECT[2] ? 6'd0 : 6'(MUL_CYCLES - 1);
            end else if (state == MUL_WAIT && cnt != 6'd0) begin
                cnt <= cnt - 6'd1;
            end else if (state == DIV_RUN && cnt != 6'd32) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt + 6'd1;
            end
        end
    end

endmodule
